// File: rtl/m_mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM encoding,
// requester ids and default tuning parameters.
package m_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_MA = 1'b1;

  localparam int MAX_MA_RUN_DEF = 2;
  localparam int TIMEOUT_DEF    = 15;

endpackage

// File: rtl/m_mem_arbiter_pick.sv
// Grant selection: the data port has priority unless it has already won
// MAX_MA_RUN times in a row while the fetch port was waiting.
module m_arb_pick (
  input  logic if_req,
  input  logic ma_req,
  input  logic ma_run_sat,
  output logic grant_ma,
  output logic valid
);

  // Pure combinational priority decision.
  always_comb begin
    valid    = if_req | ma_req;
    grant_ma = ma_req & ~(if_req & ma_run_sat);
  end

endmodule

// File: rtl/m_mem_arbiter.sv
// Two-port memory arbiter (fetch + data) in front of one shared memory port,
// with bounded data-port starvation and a BUSY-phase timeout.
module m_mem_arbiter
  import m_mem_arbiter_pkg::*;
#(
  parameter int MAX_MA_RUN = MAX_MA_RUN_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        w_clock,
  input  logic        w_reset_n,
  input  logic        w_if_req,
  input  logic [31:0] w_if_addr,
  output logic        w_if_ack,
  output logic [31:0] w_if_rdata,
  input  logic        w_ma_req,
  input  logic        w_ma_we,
  input  logic [31:0] w_ma_addr,
  input  logic [31:0] w_ma_wdata,
  output logic        w_ma_ack,
  output logic [31:0] w_ma_rdata,
  output logic        w_mem_req,
  output logic        w_mem_we,
  output logic [31:0] w_mem_addr,
  output logic [31:0] w_mem_wdata,
  input  logic [31:0] w_mem_rdata,
  input  logic        w_mem_ack,
  output logic        w_err
);

  localparam int RUN_W = (MAX_MA_RUN < 1) ? 1 : $clog2(MAX_MA_RUN + 1);

  state_t           state_r;
  state_t           state_next_s;
  logic             id_r;
  logic [RUN_W-1:0] ma_run_r;
  logic [3:0]       tmo_cnt_r;
  logic             mem_req_r;
  logic             mem_we_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wdata_r;
  logic             if_ack_r;
  logic             ma_ack_r;
  logic [31:0]      if_rdata_r;
  logic [31:0]      ma_rdata_r;
  logic             err_r;

  logic             ma_run_sat_s;
  logic             grant_ma_s;
  logic             pick_valid_s;
  logic             tmo_hit_s;
  logic             grant_s;
  logic             done_s;
  logic [31:0]      resp_data_s;

  assign ma_run_sat_s = (ma_run_r == RUN_W'(MAX_MA_RUN));
  assign tmo_hit_s    = (tmo_cnt_r == 4'(TIMEOUT - 1));

  m_arb_pick u_pick (
    .if_req     (w_if_req),
    .ma_req     (w_ma_req),
    .ma_run_sat (ma_run_sat_s),
    .grant_ma   (grant_ma_s),
    .valid      (pick_valid_s)
  );

  // State register.
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; an ack on the last allowed BUSY cycle beats the timeout.
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) state_next_s = ST_BUSY;
        else              state_next_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (w_mem_ack || tmo_hit_s) state_next_s = ST_RESP;
        else                        state_next_s = ST_BUSY;
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Transaction strobes feeding the registered outputs.
  always_comb begin
    grant_s     = 1'b0;
    done_s      = 1'b0;
    resp_data_s = 32'd0;
    case (state_r)
      ST_IDLE: grant_s = pick_valid_s;
      ST_BUSY: begin
        done_s = w_mem_ack | tmo_hit_s;
        if (w_mem_ack && !mem_we_r) resp_data_s = w_mem_rdata;
        else                        resp_data_s = 32'd0;
      end
      ST_RESP: grant_s = 1'b0;
      default: grant_s = 1'b0;
    endcase
  end

  // Latched transaction, arbitration history, timeout and response registers.
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      id_r        <= PORT_IF;
      ma_run_r    <= '0;
      tmo_cnt_r   <= 4'd0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      if_ack_r    <= 1'b0;
      ma_ack_r    <= 1'b0;
      if_rdata_r  <= 32'd0;
      ma_rdata_r  <= 32'd0;
      err_r       <= 1'b0;
    end else begin
      mem_req_r <= (state_next_s == ST_BUSY);
      if_ack_r  <= done_s & (id_r == PORT_IF);
      ma_ack_r  <= done_s & (id_r == PORT_MA);
      err_r     <= done_s & ~w_mem_ack;

      if (grant_s) begin
        id_r        <= grant_ma_s ? PORT_MA : PORT_IF;
        mem_we_r    <= grant_ma_s & w_ma_we;
        mem_addr_r  <= grant_ma_s ? w_ma_addr : w_if_addr;
        mem_wdata_r <= grant_ma_s ? w_ma_wdata : 32'd0;
        tmo_cnt_r   <= 4'd0;
        if (grant_ma_s && w_if_req)
          ma_run_r <= ma_run_sat_s ? ma_run_r : ma_run_r + RUN_W'(1);
        else
          ma_run_r <= '0;
      end else if (done_s) begin
        mem_we_r    <= 1'b0;
        mem_addr_r  <= 32'd0;
        mem_wdata_r <= 32'd0;
        tmo_cnt_r   <= 4'd0;
      end else if (state_r == ST_BUSY) begin
        tmo_cnt_r <= tmo_cnt_r + 4'd1;
      end

      if (done_s && id_r == PORT_IF) if_rdata_r <= resp_data_s;
      if (done_s && id_r == PORT_MA) ma_rdata_r <= resp_data_s;
    end
  end

  assign w_mem_req   = mem_req_r;
  assign w_mem_we    = mem_we_r;
  assign w_mem_addr  = mem_addr_r;
  assign w_mem_wdata = mem_wdata_r;
  assign w_if_ack    = if_ack_r;
  assign w_ma_ack    = ma_ack_r;
  assign w_if_rdata  = if_rdata_r;
  assign w_ma_rdata  = ma_rdata_r;
  assign w_err       = err_r;

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed self-checking bench for m_mem_arbiter; inputs change and outputs
// are sampled on the falling clock edge.
module tb_m_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        ma_req;
  logic        ma_we;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdata;
  logic        ma_ack;
  logic [31:0] ma_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int checks = 0;
  int errors = 0;

  m_mem_arbiter dut (
    .w_clock     (clk),
    .w_reset_n   (rst_n),
    .w_if_req    (if_req),
    .w_if_addr   (if_addr),
    .w_if_ack    (if_ack),
    .w_if_rdata  (if_rdata),
    .w_ma_req    (ma_req),
    .w_ma_we     (ma_we),
    .w_ma_addr   (ma_addr),
    .w_ma_wdata  (ma_wdata),
    .w_ma_ack    (ma_ack),
    .w_ma_rdata  (ma_rdata),
    .w_mem_req   (mem_req),
    .w_mem_we    (mem_we),
    .w_mem_addr  (mem_addr),
    .w_mem_wdata (mem_wdata),
    .w_mem_rdata (mem_rdata),
    .w_mem_ack   (mem_ack),
    .w_err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int n;
    int seen;
    logic exp_order [6];
    logic got_order [6];

    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0; ma_req = 1'b0; ma_we = 1'b0;
    ma_addr = 32'd0; ma_wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_acks", {30'd0, if_ack, ma_ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    // IF read, memory acks in the first BUSY cycle
    if_req = 1'b1; if_addr = 32'h0000_0040;
    tick();
    chk("if_busy_req", {31'd0, mem_req}, 32'd1);
    chk("if_busy_addr", mem_addr, 32'h0000_0040);
    chk("if_busy_we", {31'd0, mem_we}, 32'd0);
    chk("if_busy_wdata", mem_wdata, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("if_ack", {31'd0, if_ack}, 32'd1);
    chk("if_other_ack", {31'd0, ma_ack}, 32'd0);
    chk("if_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("if_err", {31'd0, err}, 32'd0);
    chk("if_resp_req", {31'd0, mem_req}, 32'd0);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();
    chk("if_ack_pulse", {31'd0, if_ack}, 32'd0);

    // MA store with 3-cycle memory latency
    ma_req = 1'b1; ma_we = 1'b1; ma_addr = 32'h0000_0080; ma_wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_busy_req", {31'd0, mem_req}, 32'd1);
      chk("st_busy_we", {31'd0, mem_we}, 32'd1);
      chk("st_busy_wdata", mem_wdata, 32'h1234_5678);
      chk("st_busy_addr", mem_addr, 32'h0000_0080);
      chk("st_no_ack", {30'd0, if_ack, ma_ack}, 32'd0);
    end
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
    tick();
    chk("st_ack", {31'd0, ma_ack}, 32'd1);
    chk("st_rdata", ma_rdata, 32'd0);
    chk("st_if_rdata_hold", if_rdata, 32'hDEAD_BEEF);
    chk("st_err", {31'd0, err}, 32'd0);
    ma_req = 1'b0; ma_we = 1'b0; mem_ack = 1'b0;
    tick();

    // Stray memory ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    chk("stray_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("stray_acks", {30'd0, if_ack, ma_ack}, 32'd0);
    chk("stray_if_rdata", if_rdata, 32'hDEAD_BEEF);
    mem_ack = 1'b0;

    // Memory never acks: timeout after 15 BUSY cycles
    if_req = 1'b1; if_addr = 32'h0000_0100;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_req) n++;
      else break;
    end
    chk("tmo_busy_cycles", n, 32'd15);
    chk("tmo_ack", {31'd0, if_ack}, 32'd1);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_rdata", if_rdata, 32'd0);
    if_req = 1'b0;
    tick();
    chk("tmo_idle_req", {31'd0, mem_req}, 32'd0);
    chk("tmo_idle_err", {31'd0, err}, 32'd0);

    // Ack on the 15th BUSY cycle wins over the timeout
    ma_req = 1'b1; ma_we = 1'b0; ma_addr = 32'h0000_0200;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (mem_req) n++;
    end
    chk("late_busy_cycles", n, 32'd15);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    chk("late_ack", {31'd0, ma_ack}, 32'd1);
    chk("late_err", {31'd0, err}, 32'd0);
    chk("late_rdata", ma_rdata, 32'hCAFE_F00D);
    ma_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Both ports requesting continuously: MA, MA, IF, MA, MA, IF
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    if_req = 1'b1; if_addr = 32'h0000_0300;
    ma_req = 1'b1; ma_addr = 32'h0000_0400;
    mem_ack = 1'b1; mem_rdata = 32'h0101_0101;
    seen = 0;
    for (int i = 0; i < 60 && seen < 6; i++) begin
      tick();
      if (if_ack || ma_ack) begin
        got_order[seen] = ma_ack;
        seen++;
      end
    end
    chk("fair_count", seen, 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < seen) chk($sformatf("fair_grant%0d", i), {31'd0, got_order[i]}, {31'd0, exp_order[i]});
    if_req = 1'b0; ma_req = 1'b0; mem_ack = 1'b0;
    tick(); tick();

    // Reset during BUSY discards the transaction; reissue completes
    if_req = 1'b1; if_addr = 32'h0000_0500;
    tick();
    chk("rstb_busy", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstb_req_low", {31'd0, mem_req}, 32'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (if_ack || ma_ack || mem_req) n++;
    end
    chk("rstb_quiet", n, 32'd0);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (if_ack) begin
        n = 1;
        break;
      end
    end
    chk("rstb_reissue_ack", n, 32'd1);
    chk("rstb_reissue_rdata", if_rdata, 32'h0BAD_CAFE);
    chk("rstb_reissue_err", {31'd0, err}, 32'd0);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_mem_arbiter.md
M_MEM_ARBITER -- requirements
Module: m_mem_arbiter

Interface
REQ-001 Parameter MAX_MA_RUN, default 2: max consecutive data-port grants while the fetch port waits.
REQ-002 Parameter TIMEOUT, default 15: max BUSY cycles without w_mem_ack before abort (4-bit counter).
REQ-003 w_clock  in  1  sole clock, rising edge.
REQ-004 w_reset_n  in  1  asynchronous, active-low reset.
REQ-005 w_if_req  in  1  fetch read request, held until w_if_ack.
REQ-006 w_if_addr  in  32  fetch address, stable while w_if_req.
REQ-007 w_if_ack  out  1  one-cycle fetch completion pulse.
REQ-008 w_if_rdata  out  32  fetch read data, registered.
REQ-009 w_ma_req  in  1  data-port request, held until w_ma_ack.
REQ-010 w_ma_we  in  1  data-port write enable (1 = store).
REQ-011 w_ma_addr  in  32  data-port address, stable while w_ma_req.
REQ-012 w_ma_wdata  in  32  store data.
REQ-013 w_ma_ack  out  1  one-cycle data-port completion pulse.
REQ-014 w_ma_rdata  out  32  load data, registered.
REQ-015 w_mem_req  out  1  shared memory request, high throughout BUSY.
REQ-016 w_mem_we  out  1  write enable to memory.
REQ-017 w_mem_addr  out  32  latched address to memory.
REQ-018 w_mem_wdata  out  32  latched store data to memory.
REQ-019 w_mem_rdata  in  32  memory read data, valid with w_mem_ack.
REQ-020 w_mem_ack  in  1  memory completion, may arrive the first BUSY cycle.
REQ-021 w_err  out  1  timeout flag, valid only with a requester ack.

Function
REQ-022 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-023 In IDLE with any request, the arbiter SHALL latch the winner's id, we, addr and wdata, then enter BUSY.
REQ-024 With a single request, that port SHALL win.
REQ-025 With both requests, MA SHALL win unless ma_run == MAX_MA_RUN, in which case IF SHALL win.
REQ-026 ma_run SHALL increment on each MA grant made while w_if_req is high, saturating at MAX_MA_RUN.
REQ-027 ma_run SHALL clear on every IF grant and on an MA grant with w_if_req low.
REQ-028 IF transactions SHALL drive w_mem_we = 0 and w_mem_wdata = 0.
REQ-029 In BUSY, w_mem_req SHALL be 1 and the mem outputs SHALL hold the latched values.
REQ-030 In BUSY, the timeout counter SHALL increment every cycle; it SHALL be zero on BUSY entry.
REQ-031 w_mem_ack sampled in BUSY SHALL capture w_mem_rdata (0 for MA writes) into the winner's rdata register and move to RESP with w_err = 0.
REQ-032 On reaching TIMEOUT BUSY cycles without w_mem_ack, the FSM SHALL move to RESP with rdata = 0 and w_err = 1.
REQ-033 If w_mem_ack coincides with the timeout cycle, the ack SHALL win (w_err = 0).
REQ-034 In RESP, exactly the winner's ack SHALL be 1 for one cycle, w_mem_req SHALL be 0, and the next state SHALL be IDLE.
REQ-035 Requests SHALL be ignored in BUSY and RESP, so a held request is never double-issued.
REQ-036 Minimum latency SHALL be 2 cycles from request sampled in IDLE to the ack cycle, with one idle turnaround cycle before the next grant.
REQ-037 Non-winner rdata registers SHALL hold their previous values.
REQ-038 w_mem_ack outside BUSY SHALL be ignored.

Reset
REQ-039 While w_reset_n = 0, the block SHALL be in IDLE with all outputs 0, ma_run = 0 and timeout counter = 0, regardless of the clock.
REQ-040 Reset mid-transaction SHALL discard it without an ack; requesters reissue.

Structure
REQ-041 A shared package SHALL hold the state encoding (IDLE=0, BUSY=1, RESP=2), the port-id constants (IF=0, MA=1) and the parameter defaults.
REQ-042 Grant selection SHALL be a sub-module, m_arb_pick, taking (if_req, ma_req, ma_run_sat) and returning grant_ma and valid; the FSM and registers stay in the top module.

Verification
REQ-043 IF-only read of 0x40, memory acks in the first BUSY cycle with 0xDEADBEEF -> w_if_ack in the 2nd cycle after sampling, w_if_rdata = 0xDEADBEEF, w_err = 0.
REQ-044 MA store of 0x12345678 to 0x80, 3-cycle memory latency -> w_mem_we = 1 and w_mem_wdata = 0x12345678 for 3 BUSY cycles, then w_ma_ack, w_ma_rdata = 0.
REQ-045 Both ports requesting continuously -> grant order MA, MA, IF, MA, MA, IF.
REQ-046 Memory never acks -> w_mem_req high exactly 15 cycles, then requester ack with w_err = 1, rdata = 0, and the FSM returns to IDLE.
REQ-047 w_mem_ack on the 15th BUSY cycle -> normal completion with w_err = 0.
REQ-048 w_reset_n low during BUSY -> w_mem_req low immediately, no ack, and the reissued request completes normally.
